// File: rtl/uart_cmd_ctrl_if.sv
// Byte links between the UART command controller, the UART and the register file.
// master = the controller; slave = the UART/register-file side.
interface uart_cmd_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) ();

  logic [DATA_WIDTH-1:0] rx_dat;
  logic                  rx_vld;
  logic                  tx_busy;
  logic [DATA_WIDTH-1:0] tx_dat;
  logic                  tx_vld;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_wr_dat;
  logic                  rf_wr_en;
  logic                  rf_rd_en;
  logic [DATA_WIDTH-1:0] rf_rd_dat;
  logic                  rf_rd_vld;
  logic                  cmd_err;

  modport master (
    input  rx_dat, rx_vld, tx_busy, rf_rd_dat, rf_rd_vld,
    output tx_dat, tx_vld, rf_addr, rf_wr_dat, rf_wr_en, rf_rd_en, cmd_err
  );

  modport slave (
    output rx_dat, rx_vld, tx_busy, rf_rd_dat, rf_rd_vld,
    input  tx_dat, tx_vld, rf_addr, rf_wr_dat, rf_wr_en, rf_rd_en, cmd_err
  );

endinterface

// File: rtl/uart_cmd_ctrl.sv
// Decodes UART write (CMD,ADDR,DATA) / read (CMD,ADDR) frames into register-file strobes, 1 cycle
// after the last frame byte; read replies wait in TX_SEND while tx_busy is high (rx bytes then dropped).
module uart_cmd_ctrl #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB
) (
  input  logic            clk,
  input  logic            rst,
  uart_cmd_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.tx_dat    <= '0;
      bus.tx_vld    <= 1'b0;
      bus.rf_addr   <= '0;
      bus.rf_wr_dat <= '0;
      bus.rf_wr_en  <= 1'b0;
      bus.rf_rd_en  <= 1'b0;
      bus.cmd_err   <= 1'b0;
    end else begin
      bus.tx_vld   <= 1'b0;
      bus.rf_wr_en <= 1'b0;
      bus.rf_rd_en <= 1'b0;
      bus.cmd_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.rx_vld) begin
            if (bus.rx_dat == WR_CMD) begin
              state <= WR_ADDR;
            end else if (bus.rx_dat == RD_CMD) begin
              state <= RD_ADDR;
            end else begin
              bus.cmd_err <= 1'b1;
            end
          end
        end

        // Operand states take any byte value, command codes included.
        WR_ADDR: begin
          if (bus.rx_vld) begin
            bus.rf_addr <= bus.rx_dat[ADDR_WIDTH-1:0];
            state       <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (bus.rx_vld) begin
            bus.rf_wr_dat <= bus.rx_dat;
            bus.rf_wr_en  <= 1'b1;
            state         <= IDLE;
          end
        end

        RD_ADDR: begin
          if (bus.rx_vld) begin
            bus.rf_addr  <= bus.rx_dat[ADDR_WIDTH-1:0];
            bus.rf_rd_en <= 1'b1;
            state        <= RD_WAIT;
          end
        end

        // Read data may arrive in the same cycle as the rd strobe.
        RD_WAIT: begin
          if (bus.rx_vld) begin
            bus.cmd_err <= 1'b1;
          end
          if (bus.rf_rd_vld) begin
            bus.tx_dat <= bus.rf_rd_dat;
            state      <= TX_SEND;
          end
        end

        TX_SEND: begin
          if (bus.rx_vld) begin
            bus.cmd_err <= 1'b1;
          end
          if (!bus.tx_busy) begin
            bus.tx_vld <= 1'b1;
            state      <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized and directed frames against a frame-level reference model of the command controller.
module tb_uart_cmd_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  uart_cmd_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .WR_CMD    (8'hAA),
    .RD_CMD    (8'hBB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: bytes of the frame in progress plus the read-reply phase
  // (0 = accepting frames, 1 = awaiting register data, 2 = reply ready to send).
  logic [7:0] ref_mem [16];
  logic [7:0] rf_mem  [16];
  logic [7:0] frame   [$];
  int         phase;
  logic [3:0] m_addr;
  logic [7:0] m_wdat, m_txdat;
  logic       m_wr, m_rd, m_tx, m_err;

  bit         rsp_act;
  int         rsp_cnt;
  logic [3:0] rsp_addr;
  int         rd_lat;
  int         n_tx;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_cycle();
    logic [7:0] b;
    m_wr  = 1'b0;
    m_rd  = 1'b0;
    m_tx  = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      frame.delete();
      phase   = 0;
      m_addr  = '0;
      m_wdat  = '0;
      m_txdat = '0;
    end else if (phase == 1) begin
      if (bus.rx_vld) m_err = 1'b1;
      if (bus.rf_rd_vld) begin
        m_txdat = ref_mem[m_addr];
        phase   = 2;
      end
    end else if (phase == 2) begin
      if (bus.rx_vld) m_err = 1'b1;
      if (!bus.tx_busy) begin
        m_tx  = 1'b1;
        phase = 0;
      end
    end else if (bus.rx_vld) begin
      frame.push_back(bus.rx_dat);
      b = frame[0];
      if (b != 8'hAA && b != 8'hBB) begin
        m_err = 1'b1;
        frame.delete();
      end else if (frame.size() == 2) begin
        b      = frame[1];
        m_addr = b[3:0];
        if (frame[0] == 8'hBB) begin
          m_rd  = 1'b1;
          phase = 1;
          frame.delete();
        end
      end else if (frame.size() == 3) begin
        m_wdat          = frame[2];
        m_wr            = 1'b1;
        ref_mem[m_addr] = m_wdat;
        frame.delete();
      end
    end
  endtask

  // One clock: register-file responder, model update, edge, then compare.
  task automatic step();
    if (bus.rf_wr_en === 1'b1) rf_mem[bus.rf_addr] = bus.rf_wr_dat;
    if (bus.rf_rd_en === 1'b1) begin
      rsp_act  = 1'b1;
      rsp_cnt  = (rd_lat < 0) ? int'($urandom_range(0, 3)) : rd_lat;
      rsp_addr = bus.rf_addr;
    end
    bus.rf_rd_vld = 1'b0;
    bus.rf_rd_dat = 8'($urandom);
    if (rst) begin
      rsp_act = 1'b0;
    end else if (rsp_act) begin
      if (rsp_cnt == 0) begin
        bus.rf_rd_vld = 1'b1;
        bus.rf_rd_dat = rf_mem[rsp_addr];
        rsp_act       = 1'b0;
      end else begin
        rsp_cnt--;
      end
    end else if (phase != 1 && $urandom_range(0, 7) == 0) begin
      bus.rf_rd_vld = 1'b1;
    end
    model_cycle();
    @(posedge clk);
    #1;
    chk_eq("rf_wr_en", bus.rf_wr_en, m_wr);
    chk_eq("rf_rd_en", bus.rf_rd_en, m_rd);
    chk_eq("tx_vld", bus.tx_vld, m_tx);
    chk_eq("cmd_err", bus.cmd_err, m_err);
    chk_eq("rf_addr", bus.rf_addr, m_addr);
    chk_eq("rf_wr_dat", bus.rf_wr_dat, m_wdat);
    chk_eq("tx_dat", bus.tx_dat, m_txdat);
    if (bus.tx_vld === 1'b1) n_tx++;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_vld = 1'b1;
    bus.rx_dat = b;
    step();
    bus.rx_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    logic [7:0] txq [$];
    int n0;

    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'($urandom);
      rf_mem[i]  = ref_mem[i];
    end
    ref_mem[7]    = 8'h9E;
    rf_mem[7]     = 8'h9E;
    bus.rx_vld    = 1'b0;
    bus.rx_dat    = '0;
    bus.tx_busy   = 1'b0;
    bus.rf_rd_vld = 1'b0;
    bus.rf_rd_dat = '0;
    rsp_act       = 1'b0;
    rsp_cnt       = 0;
    rsp_addr      = '0;
    rd_lat        = 2;
    n_tx          = 0;
    phase         = 0;
    rst           = 1'b1;
    idle(2);
    rst = 1'b0;

    // Reset in the middle of a write frame, then a clean write.
    send(8'hAA);
    send(8'h03);
    rst = 1'b1;
    idle(2);
    chk_eq("rst_addr", bus.rf_addr, 0);
    chk_eq("rst_wr_en", bus.rf_wr_en, 0);
    rst = 1'b0;
    idle(1);
    send(8'hAA);
    send(8'h03);
    send(8'h5C);
    chk_eq("wr_strobe", bus.rf_wr_en, 1);
    chk_eq("wr_addr", bus.rf_addr, 4'h3);
    chk_eq("wr_dat", bus.rf_wr_dat, 8'h5C);
    idle(2);

    // Read with reply two cycles after the rd strobe.
    send(8'hBB);
    send(8'h07);
    chk_eq("rd_strobe", bus.rf_rd_en, 1);
    chk_eq("rd_addr", bus.rf_addr, 4'h7);
    n0 = n_tx;
    idle(6);
    chk_eq("rd_reply_cnt", n_tx - n0, 1);
    chk_eq("rd_reply_dat", bus.tx_dat, 8'h9E);

    // Transmitter backpressure.
    bus.tx_busy = 1'b1;
    send(8'hBB);
    send(8'h07);
    n0 = n_tx;
    idle(20);
    chk_eq("bp_hold_cnt", n_tx - n0, 0);
    bus.tx_busy = 1'b0;
    idle(3);
    chk_eq("bp_send_cnt", n_tx - n0, 1);
    chk_eq("bp_dat", bus.tx_dat, 8'h9E);

    // Bad command byte, and a stray byte while a read is outstanding.
    send(8'h12);
    chk_eq("err_idle", bus.cmd_err, 1);
    idle(2);
    rd_lat = 3;
    send(8'hBB);
    send(8'h07);
    send(8'h55);
    chk_eq("err_rdwait", bus.cmd_err, 1);
    n0 = n_tx;
    idle(6);
    chk_eq("err_reply_cnt", n_tx - n0, 1);
    chk_eq("err_reply_dat", bus.tx_dat, 8'h9E);

    // Back-to-back write then read of the same register; address truncation.
    rd_lat = 0;
    send(8'hAA);
    send(8'h0F);
    send(8'hFF);
    send(8'hBB);
    send(8'h0F);
    idle(4);
    chk_eq("b2b_reply", bus.tx_dat, 8'hFF);
    send(8'hAA);
    send(8'hF3);
    send(8'h11);
    chk_eq("trunc_addr", bus.rf_addr, 4'h3);
    idle(2);

    // Random traffic.
    rd_lat = -1;
    for (int c = 0; c < 4000; c++) begin
      if (txq.size() == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: begin
            txq.push_back(8'hAA);
            txq.push_back(8'($urandom));
            txq.push_back(8'($urandom));
          end
          4, 5, 6, 7: begin
            txq.push_back(8'hBB);
            txq.push_back(8'($urandom));
          end
          8: txq.push_back(8'($urandom));
          default: ;
        endcase
      end
      rst         = ($urandom_range(0, 399) == 0);
      bus.tx_busy = ($urandom_range(0, 3) != 0);
      bus.rx_vld  = 1'b0;
      if (phase != 0) begin
        if ($urandom_range(0, 15) == 0) begin
          bus.rx_vld = 1'b1;
          bus.rx_dat = 8'($urandom);
        end
      end else if (txq.size() > 0 && $urandom_range(0, 2) != 0) begin
        bus.rx_vld = 1'b1;
        bus.rx_dat = txq.pop_front();
      end
      step();
    end
    rst        = 1'b0;
    bus.rx_vld = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
